div_8_4_seq: RTL

//  Sequential restoring divider for the Abacus calculator: 8-bit unsigned dividend / 4-bit unsigned divisor.

---
 rtl/div_8_4_seq_pkg.sv | 17 +
 rtl/div_8_4_seq_div_step.sv | 28 ++
 rtl/div_8_4_seq.sv | 128 ++++++++++++
 3 files changed

// File: rtl/div_8_4_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_8_4_seq_pkg
//  Brief    : Shared widths and FSM state encodings for the Abacus divider.
//  Revision : 1.0 - initial release
// ============================================================================
package div_8_4_seq_pkg;

    localparam int ABACUS_WA = 8;
    localparam int ABACUS_WB = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/div_8_4_seq_div_step.sv
`default_nettype none
// ============================================================================
//  Module   : div_step
//  Brief    : One combinational restoring-division step (shift in, compare,
//             conditionally subtract).
//  Revision : 1.0 - initial release
// ============================================================================
module div_step
    import div_8_4_seq_pkg::*;
#(
    parameter int WB = ABACUS_WB
) (
    input  logic [WB-1:0] p,
    input  logic          a_bit,
    input  logic [WB-1:0] b,
    output logic [WB-1:0] p_next,
    output logic          q_bit
);

    logic [WB:0] w_p_sh;

    assign w_p_sh = {p, a_bit};
    assign q_bit  = (w_p_sh >= {1'b0, b});
    // A restored remainder is always below b, so WB-bit arithmetic is exact.
    assign p_next = q_bit ? (w_p_sh[WB-1:0] - b) : w_p_sh[WB-1:0];

endmodule
`default_nettype wire

// File: rtl/div_8_4_seq.sv
`default_nettype none
// ============================================================================
//  Module   : div_8_4_seq
//  Brief    : Sequential restoring divider, one quotient bit per clock, with
//             start/busy/done handshake. Optional macro DIV_ZERO_DET_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module div_8_4_seq
    import div_8_4_seq_pkg::*;
#(
    parameter int WA = ABACUS_WA,
    parameter int WB = ABACUS_WB
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic [WA-1:0] dividend,
    input  logic [WB-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [WA-1:0] quotient,
    output logic [WB-1:0] remainder,
    output logic          div_err
);

    localparam int            CW         = (WA > 1) ? $clog2(WA) : 1;
    localparam logic [CW-1:0] c_cnt_init = CW'(WA - 1);

    logic [1:0]    r_state;
    logic [WA-1:0] r_a_sh;
    logic [WA-1:0] r_q_sh;
    logic [WB-1:0] r_b;
    logic [WB-1:0] r_p;
    logic [CW-1:0] r_cnt;
    logic          r_done;
    logic [WA-1:0] r_quotient;
    logic [WB-1:0] r_remainder;
    logic [WB-1:0] w_p_next;
    logic          w_q_bit;
`ifdef DIV_ZERO_DET_EN
    logic          r_zero;
    logic          r_div_err;
`endif

    div_step #(.WB(WB)) u_step (
        .p      (r_p),
        .a_bit  (r_a_sh[WA-1]),
        .b      (r_b),
        .p_next (w_p_next),
        .q_bit  (w_q_bit)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state     <= ST_IDLE;
            r_a_sh      <= '0;
            r_q_sh      <= '0;
            r_b         <= '0;
            r_p         <= '0;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
`ifdef DIV_ZERO_DET_EN
            r_zero      <= 1'b0;
            r_div_err   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a_sh <= dividend;
                        r_b    <= divisor;
                        r_p    <= '0;
                        r_q_sh <= '0;
                        r_cnt  <= c_cnt_init;
`ifdef DIV_ZERO_DET_EN
                        r_zero <= (divisor == '0);
                        // Short-circuit to the same result a full zero-divisor run gives.
                        if (divisor == '0) begin
                            r_q_sh  <= '1;
                            r_p     <= dividend[WB-1:0];
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_RUN;
                        end
`else
                        r_state <= ST_RUN;
`endif
                    end
                end
                ST_RUN: begin
                    r_p    <= w_p_next;
                    r_a_sh <= r_a_sh << 1;
                    r_q_sh <= {r_q_sh[WA-2:0], w_q_bit};
                    if (r_cnt == '0) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_quotient  <= r_q_sh;
                    r_remainder <= r_p;
                    r_done      <= 1'b1;
`ifdef DIV_ZERO_DET_EN
                    r_div_err   <= r_zero;
`endif
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
`ifdef DIV_ZERO_DET_EN
    assign div_err   = r_div_err;
`else
    assign div_err   = 1'b0;
`endif

endmodule
`default_nettype wire
